// File: rtl/riscv_lsu_pkg.sv
// Shared definitions for the dmem load/store unit: funct3 codes, FSM state
// encoding and the request legality / alignment helpers.
package riscv_lsu_pkg;

    // RV32I load/store width codes (stores only use B/H/W)
    localparam logic [2:0] F3_B  = 3'd0;
    localparam logic [2:0] F3_H  = 3'd1;
    localparam logic [2:0] F3_W  = 3'd2;
    localparam logic [2:0] F3_BU = 3'd4;
    localparam logic [2:0] F3_HU = 3'd5;

    // FSM state encoding
    localparam logic [2:0] ST_IDLE   = 3'd0;
    localparam logic [2:0] ST_LOAD   = 3'd1;
    localparam logic [2:0] ST_RMW_RD = 3'd2;
    localparam logic [2:0] ST_STORE  = 3'd3;
    localparam logic [2:0] ST_RESP   = 3'd4;

    // A load may use any of the five width codes, a store only B/H/W.
    function automatic logic is_legal_f3(input logic we, input logic [2:0] f3);
        logic legal;
        if (we) begin
            legal = (f3 == F3_B) || (f3 == F3_H) || (f3 == F3_W);
        end else begin
            legal = (f3 == F3_B) || (f3 == F3_H) || (f3 == F3_W) ||
                    (f3 == F3_BU) || (f3 == F3_HU);
        end
        return legal;
    endfunction

    // Halfwords need an even address, words a multiple of four.
    function automatic logic is_misaligned(input logic [2:0] f3, input logic [1:0] addrLow);
        logic bad;
        bad = 1'b0;
        if (f3[1:0] == 2'b01) begin
            bad = addrLow[0];
        end else if (f3[1:0] == 2'b10) begin
            bad = (addrLow != 2'b00);
        end
        return bad;
    endfunction

endpackage

// File: rtl/dmem_lsu_ext.sv
// Combinational data shaping for the load/store unit: extracts and extends
// the addressed byte/half/word from dmem read data for loads, and merges the
// store byte/half into the surrounding read data for read-modify-write.
module dmem_lsu_ext
    import riscv_lsu_pkg::*;
(
    input  logic [31:0] mem_out_i,
    input  logic [2:0]  f3_i,
    input  logic [31:0] wdata_i,
    output logic [31:0] rdata_o,
    output logic [31:0] merged_o
);

    // Load extraction: sign or zero extend the low byte/half, or pass the word
    always_comb begin
        rdata_o = '0;
        unique case (f3_i)
            F3_B:    rdata_o = {{24{mem_out_i[7]}}, mem_out_i[7:0]};
            F3_H:    rdata_o = {{16{mem_out_i[15]}}, mem_out_i[15:0]};
            F3_W:    rdata_o = mem_out_i;
            F3_BU:   rdata_o = {24'h0, mem_out_i[7:0]};
            F3_HU:   rdata_o = {16'h0, mem_out_i[15:0]};
            default: rdata_o = '0;
        endcase
    end

    // Store merge: keep the bytes above the stored lane from the memory word
    always_comb begin
        merged_o = wdata_i;
        unique case (f3_i[1:0])
            2'b00:   merged_o = {mem_out_i[31:8], wdata_i[7:0]};
            2'b01:   merged_o = {mem_out_i[31:16], wdata_i[15:0]};
            default: merged_o = wdata_i;
        endcase
    end

endmodule

// File: rtl/dmem_lsu.sv
// Load/store unit driving the dmem port. One request at a time; sub-word
// stores are read-modify-write because dmem always writes four bytes.
// Optional feature macro: DMEM_LSU_MISALIGN_TRAP_EN -- when defined,
// misaligned halfword/word accesses are rejected with rsp_err instead of
// being performed byte-addressed.
module dmem_lsu
    import riscv_lsu_pkg::*;
#(
    parameter int AddrWidth = 32,
    parameter int DataWidth = 32
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 req_valid,
    output logic                 req_ready,
    input  logic                 req_we,
    input  logic [2:0]           req_funct3,
    input  logic [AddrWidth-1:0] req_addr,
    input  logic [DataWidth-1:0] req_wdata,
    output logic                 rsp_valid,
    output logic [DataWidth-1:0] rsp_rdata,
    output logic                 rsp_err,
    output logic [AddrWidth-1:0] mem_addr,
    output logic [DataWidth-1:0] mem_data,
    output logic                 r_w,
    input  logic [DataWidth-1:0] mem_out
);

    logic [2:0]           state_q, state_d;
    logic [AddrWidth-1:0] mem_addr_q, mem_addr_d;
    logic [DataWidth-1:0] mem_data_q, mem_data_d;
    logic [DataWidth-1:0] wdata_q, wdata_d;
    logic [DataWidth-1:0] rdata_q, rdata_d;
    logic [2:0]           f3_q, f3_d;
    logic                 err_q, err_d;

    logic                 accept;
    logic                 reqErr;
    logic [31:0]          extRdata;
    logic [31:0]          extMerged;

    assign accept = req_valid && (state_q == ST_IDLE);

    dmem_lsu_ext u_ext (
        .mem_out_i (mem_out),
        .f3_i      (f3_q),
        .wdata_i   (wdata_q),
        .rdata_o   (extRdata),
        .merged_o  (extMerged)
    );

    // Decide whether an incoming request is rejected without touching memory
    always_comb begin
        reqErr = !is_legal_f3(req_we, req_funct3);
`ifdef DMEM_LSU_MISALIGN_TRAP_EN
        if (is_misaligned(req_funct3, req_addr[1:0])) begin
            reqErr = 1'b1;
        end
`endif
    end

    // State register; reset aborts any access in flight, dropping r_w at once
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q <= ST_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state logic: route each request by kind, then walk to RESP and IDLE
    always_comb begin
        state_d = state_q;
        unique case (state_q)
            ST_IDLE: begin
                if (accept) begin
                    if (reqErr) begin
                        state_d = ST_RESP;
                    end else if (!req_we) begin
                        state_d = ST_LOAD;
                    end else if (req_funct3 == F3_W) begin
                        state_d = ST_STORE;
                    end else begin
                        state_d = ST_RMW_RD;
                    end
                end
            end
            ST_LOAD:   state_d = ST_RESP;
            ST_RMW_RD: state_d = ST_STORE;
            ST_STORE:  state_d = ST_RESP;
            ST_RESP:   state_d = ST_IDLE;
            default:   state_d = ST_IDLE;
        endcase
    end

    // Output logic: handshake, response and dmem strobes decoded from the state
    always_comb begin
        req_ready = (state_q == ST_IDLE);
        rsp_valid = (state_q == ST_RESP);
        rsp_err   = (state_q == ST_RESP) && err_q;
        rsp_rdata = (state_q == ST_RESP) ? rdata_q : '0;
        r_w       = (state_q == ST_STORE);
        mem_addr  = mem_addr_q;
        mem_data  = mem_data_q;
    end

    // Datapath register file for the latched request and memory port
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            mem_addr_q <= '0;
            mem_data_q <= '0;
            wdata_q    <= '0;
            rdata_q    <= '0;
            f3_q       <= '0;
            err_q      <= 1'b0;
        end else begin
            mem_addr_q <= mem_addr_d;
            mem_data_q <= mem_data_d;
            wdata_q    <= wdata_d;
            rdata_q    <= rdata_d;
            f3_q       <= f3_d;
            err_q      <= err_d;
        end
    end

    // Datapath next values: latch on accept, capture load data, build RMW word
    always_comb begin
        mem_addr_d = mem_addr_q;
        mem_data_d = mem_data_q;
        wdata_d    = wdata_q;
        rdata_d    = rdata_q;
        f3_d       = f3_q;
        err_d      = err_q;
        unique case (state_q)
            ST_IDLE: begin
                if (accept) begin
                    mem_addr_d = req_addr;
                    wdata_d    = req_wdata;
                    f3_d       = req_funct3;
                    err_d      = reqErr;
                    rdata_d    = '0;
                    if (req_we && (req_funct3 == F3_W) && !reqErr) begin
                        mem_data_d = req_wdata;
                    end
                end
            end
            ST_LOAD:   rdata_d    = extRdata;
            ST_RMW_RD: mem_data_d = extMerged;
            default: begin
            end
        endcase
    end

endmodule

// File: tb/tb_dmem_lsu.sv
// Self-checking bench for dmem_lsu with a byte-addressed dmem model.
// Honours DMEM_LSU_MISALIGN_TRAP_EN for the misaligned-access expectations.
module tb_dmem_lsu;
    import riscv_lsu_pkg::*;

`ifdef DMEM_LSU_MISALIGN_TRAP_EN
    localparam bit TrapEn = 1'b1;
`else
    localparam bit TrapEn = 1'b0;
`endif

    localparam int NumVecs = 27;

    typedef struct {
        logic        we;
        logic [2:0]  f3;
        logic [31:0] addr;
        logic [31:0] wdata;
        logic [31:0] expRdata;
        logic        expErr;
        int          expLat;
        int          expWrites;
    } vec_t;

    typedef struct packed {
        logic [31:0] rdata;
        logic        err;
    } rsp_t;

    logic        clk = 1'b0;
    logic        reset;
    logic        reqValid;
    logic        reqReady;
    logic        reqWe;
    logic [2:0]  reqFunct3;
    logic [31:0] reqAddr;
    logic [31:0] reqWdata;
    logic        rspValid;
    logic [31:0] rspRdata;
    logic        rspErr;
    logic [31:0] memAddr;
    logic [31:0] memData;
    logic        rW;
    logic [31:0] memOut;

    logic [7:0]  mem [0:255];
    logic [7:0]  memA;
    logic        loadMem;

    rsp_t        expQ[$];
    vec_t        vecs[NumVecs];
    int          compared = 0;
    int          mismatched = 0;
    int          rwCount = 0;
    int          rspCount = 0;

    // Free-running clock, 10 time units per cycle
    always #5 clk = ~clk;

    dmem_lsu #(
        .AddrWidth (32),
        .DataWidth (32)
    ) dut (
        .clk        (clk),
        .reset      (reset),
        .req_valid  (reqValid),
        .req_ready  (reqReady),
        .req_we     (reqWe),
        .req_funct3 (reqFunct3),
        .req_addr   (reqAddr),
        .req_wdata  (reqWdata),
        .rsp_valid  (rspValid),
        .rsp_rdata  (rspRdata),
        .rsp_err    (rspErr),
        .mem_addr   (memAddr),
        .mem_data   (memData),
        .r_w        (rW),
        .mem_out    (memOut)
    );

    assign memA = memAddr[7:0];

    // dmem read port: little-endian, byte at mem_addr lands in [7:0]
    always_comb begin
        memOut = {mem[memA + 8'd3], mem[memA + 8'd2], mem[memA + 8'd1], mem[memA]};
    end

    // dmem write port plus the preload of known words used by the tests
    always @(posedge clk) begin
        if (loadMem) begin
            for (int i = 0; i < 256; i++) mem[i] <= 8'h00;
            {mem[8'h07], mem[8'h06], mem[8'h05], mem[8'h04]} <= 32'h44332211;
            {mem[8'h0B], mem[8'h0A], mem[8'h09], mem[8'h08]} <= 32'h88776655;
            {mem[8'h23], mem[8'h22], mem[8'h21], mem[8'h20]} <= 32'h11223344;
            {mem[8'h27], mem[8'h26], mem[8'h25], mem[8'h24]} <= 32'hAAAAAAAA;
            {mem[8'h33], mem[8'h32], mem[8'h31], mem[8'h30]} <= 32'h12345678;
            {mem[8'h43], mem[8'h42], mem[8'h41], mem[8'h40]} <= 32'h55667788;
        end else if (rW) begin
            mem[memA]         <= memData[7:0];
            mem[memA + 8'd1]  <= memData[15:8];
            mem[memA + 8'd2]  <= memData[23:16];
            mem[memA + 8'd3]  <= memData[31:24];
        end
    end

    // One comparison: count it, and report a FAIL line when it disagrees
    task automatic checkOutput(input string name, input logic [31:0] actual,
                               input logic [31:0] expected);
        compared++;
        if (actual !== expected) begin
            mismatched++;
            $display("[TB] FAIL %s: got 0x%08h, want 0x%08h", name, actual, expected);
        end
    endtask

    // Scoreboard side: every response pops the oldest expectation
    always @(negedge clk) begin
        if (rW) rwCount++;
        if (!reset && rspValid) begin
            rspCount++;
            if (expQ.size() == 0) begin
                compared++;
                mismatched++;
                $display("[TB] FAIL unexpected_rsp: got rdata 0x%08h err %0b, want no response",
                         rspRdata, rspErr);
            end else begin
                rsp_t exp;
                exp = expQ.pop_front();
                checkOutput("rsp_rdata", rspRdata, exp.rdata);
                checkOutput("rsp_err", {31'b0, rspErr}, {31'b0, exp.err});
            end
        end
    end

    // Issue one request, push its expected response, then check timing,
    // handshake behaviour and the number of dmem writes it caused
    task automatic applyStimulus(input logic we, input logic [2:0] f3,
                                 input logic [31:0] addr, input logic [31:0] wdata,
                                 input logic [31:0] expRdata, input logic expErr,
                                 input int expLat, input int expWrites,
                                 input bit hold, input string tag);
        int waitCnt;
        int lat;
        int rwStart;
        int rspStart;
        bit seen;
        bit busyBad;
        rsp_t exp;

        @(negedge clk);
        reqValid  = 1'b1;
        reqWe     = we;
        reqFunct3 = f3;
        reqAddr   = addr;
        reqWdata  = wdata;
        waitCnt   = 0;
        while (!reqReady && waitCnt < 20) begin
            @(negedge clk);
            waitCnt++;
        end
        if (!reqReady) begin
            compared++;
            mismatched++;
            $display("[TB] FAIL %s_accept: got req_ready 0 for 20 cycles, want 1", tag);
            reqValid = 1'b0;
            return;
        end
        exp.rdata = expRdata;
        exp.err   = expErr;
        expQ.push_back(exp);
        rwStart  = rwCount;
        rspStart = rspCount;
        @(posedge clk);

        lat     = 0;
        seen    = 1'b0;
        busyBad = 1'b0;
        while (!seen && lat < 20) begin
            @(negedge clk);
            lat++;
            if (!hold) reqValid = 1'b0;
            if (rspValid) seen = 1'b1;
            else if (reqReady) busyBad = 1'b1;
        end
        reqValid = 1'b0;
        checkOutput({tag, "_latency"}, 32'(lat), 32'(expLat));
        checkOutput({tag, "_ready_busy"}, 32'(busyBad), 32'd0);

        @(negedge clk);
        checkOutput({tag, "_ready_after"}, {31'b0, reqReady}, 32'd1);
        checkOutput({tag, "_writes"}, 32'(rwCount - rwStart), 32'(expWrites));
        checkOutput({tag, "_rsp_count"}, 32'(rspCount - rspStart), 32'd1);
    endtask

    // Safety net so a stuck design can never hang the run
    initial begin
        #200000;
        $display("[TB] FAIL watchdog: got simulation still running, want finished");
        $fatal(1, "[TB] watchdog expired");
    end

    // Main test sequence
    initial begin
        // Vector table: {we, f3, addr, wdata, expRdata, expErr, expLat, expWrites}
        vecs[0]  = '{1'b1, F3_W,  32'h10, 32'hDEADBEEF, 32'h00000000, 1'b0, 2, 1};
        vecs[1]  = '{1'b0, F3_W,  32'h10, 32'h0,        32'hDEADBEEF, 1'b0, 2, 0};
        vecs[2]  = '{1'b1, F3_B,  32'h20, 32'h12345680, 32'h00000000, 1'b0, 3, 1};
        vecs[3]  = '{1'b0, F3_W,  32'h20, 32'h0,        32'h11223380, 1'b0, 2, 0};
        vecs[4]  = '{1'b0, F3_B,  32'h20, 32'h0,        32'hFFFFFF80, 1'b0, 2, 0};
        vecs[5]  = '{1'b0, F3_BU, 32'h20, 32'h0,        32'h00000080, 1'b0, 2, 0};
        vecs[6]  = '{1'b1, F3_H,  32'h24, 32'h1234BEEF, 32'h00000000, 1'b0, 3, 1};
        vecs[7]  = '{1'b0, F3_W,  32'h24, 32'h0,        32'hAAAABEEF, 1'b0, 2, 0};
        vecs[8]  = '{1'b0, F3_H,  32'h24, 32'h0,        32'hFFFFBEEF, 1'b0, 2, 0};
        vecs[9]  = '{1'b0, F3_HU, 32'h24, 32'h0,        32'h0000BEEF, 1'b0, 2, 0};
        vecs[10] = '{1'b1, 3'd3,  32'h40, 32'hFFFFFFFF, 32'h00000000, 1'b1, 1, 0};
        vecs[11] = '{1'b0, F3_W,  32'h40, 32'h0,        32'h55667788, 1'b0, 2, 0};
        vecs[12] = '{1'b0, 3'd6,  32'h40, 32'h0,        32'h00000000, 1'b1, 1, 0};
        vecs[13] = '{1'b0, 3'd7,  32'h40, 32'h0,        32'h00000000, 1'b1, 1, 0};
        vecs[14] = '{1'b1, 3'd5,  32'h40, 32'hFFFFFFFF, 32'h00000000, 1'b1, 1, 0};
        vecs[15] = '{1'b0, F3_B,  32'h40, 32'h0,        32'hFFFFFF88, 1'b0, 2, 0};
        vecs[16] = '{1'b0, F3_B,  32'h41, 32'h0,        32'h00000077, 1'b0, 2, 0};
        vecs[17] = '{1'b0, F3_H,  32'h40, 32'h0,        32'h00007788, 1'b0, 2, 0};
        vecs[18] = '{1'b0, F3_H,  32'h42, 32'h0,        32'h00005566, 1'b0, 2, 0};
        vecs[19] = '{1'b1, F3_B,  32'h43, 32'hFFFFFFA5, 32'h00000000, 1'b0, 3, 1};
        vecs[20] = '{1'b0, F3_W,  32'h40, 32'h0,        32'hA5667788, 1'b0, 2, 0};
        vecs[21] = TrapEn ? '{1'b0, F3_W, 32'h05, 32'h0, 32'h00000000, 1'b1, 1, 0}
                          : '{1'b0, F3_W, 32'h05, 32'h0, 32'h55443322, 1'b0, 2, 0};
        vecs[22] = TrapEn ? '{1'b0, F3_H, 32'h41, 32'h0, 32'h00000000, 1'b1, 1, 0}
                          : '{1'b0, F3_H, 32'h41, 32'h0, 32'h00006677, 1'b0, 2, 0};
        vecs[23] = TrapEn ? '{1'b1, F3_W, 32'h0A, 32'hCAFEF00D, 32'h00000000, 1'b1, 1, 0}
                          : '{1'b1, F3_W, 32'h0A, 32'hCAFEF00D, 32'h00000000, 1'b0, 2, 1};
        vecs[24] = TrapEn ? '{1'b0, F3_W, 32'h08, 32'h0, 32'h88776655, 1'b0, 2, 0}
                          : '{1'b0, F3_W, 32'h08, 32'h0, 32'hF00D6655, 1'b0, 2, 0};
        vecs[25] = '{1'b0, F3_HU, 32'h20, 32'h0,        32'h00003380, 1'b0, 2, 0};
        vecs[26] = '{1'b0, F3_B,  32'h43, 32'h0,        32'hFFFFFFA5, 1'b0, 2, 0};

        reset     = 1'b1;
        loadMem   = 1'b1;
        reqValid  = 1'b0;
        reqWe     = 1'b0;
        reqFunct3 = 3'd0;
        reqAddr   = 32'h0;
        reqWdata  = 32'h0;
        repeat (2) @(posedge clk);
        @(negedge clk);

        // Reset state of every output
        checkOutput("reset_rsp_valid", {31'b0, rspValid}, 32'd0);
        checkOutput("reset_rsp_rdata", rspRdata, 32'd0);
        checkOutput("reset_rsp_err", {31'b0, rspErr}, 32'd0);
        checkOutput("reset_mem_addr", memAddr, 32'd0);
        checkOutput("reset_mem_data", memData, 32'd0);
        checkOutput("reset_r_w", {31'b0, rW}, 32'd0);
        checkOutput("reset_req_ready", {31'b0, reqReady}, 32'd1);
        loadMem = 1'b0;
        reset   = 1'b0;

        $display("[TB] running %0d table vectors (misalign trap %0b)", NumVecs, TrapEn);
        for (int i = 0; i < NumVecs; i++) begin
            applyStimulus(vecs[i].we, vecs[i].f3, vecs[i].addr, vecs[i].wdata,
                          vecs[i].expRdata, vecs[i].expErr, vecs[i].expLat,
                          vecs[i].expWrites, 1'b0, $sformatf("v%0d", i));
        end

        // Reset while the SW sits in STORE: r_w must fall immediately, no write
        $display("[TB] reset during store");
        @(negedge clk);
        reqValid  = 1'b1;
        reqWe     = 1'b1;
        reqFunct3 = F3_W;
        reqAddr   = 32'h30;
        reqWdata  = 32'hFFFFFFFF;
        @(posedge clk);
        @(negedge clk);
        reqValid = 1'b0;
        checkOutput("rst_mid_rw_before", {31'b0, rW}, 32'd1);
        reset = 1'b1;
        #1;
        checkOutput("rst_mid_rw_drop", {31'b0, rW}, 32'd0);
        checkOutput("rst_mid_mem_addr", memAddr, 32'd0);
        checkOutput("rst_mid_ready", {31'b0, reqReady}, 32'd1);
        @(posedge clk);
        @(negedge clk);
        reset = 1'b0;
        applyStimulus(1'b0, F3_W, 32'h30, 32'h0, 32'h12345678, 1'b0, 2, 0, 1'b0, "rst_readback");

        // Requests held valid through their busy cycles: one response each
        $display("[TB] held request sequence");
        applyStimulus(1'b1, F3_W, 32'h50, 32'h0BADF00D, 32'h0, 1'b0, 2, 1, 1'b1, "hold_sw");
        applyStimulus(1'b0, F3_W, 32'h50, 32'h0, 32'h0BADF00D, 1'b0, 2, 0, 1'b1, "hold_lw1");
        applyStimulus(1'b1, F3_B, 32'h51, 32'h0000007E, 32'h0, 1'b0, 3, 1, 1'b1, "hold_sb");
        applyStimulus(1'b0, F3_W, 32'h50, 32'h0, 32'h0BAD7E0D, 1'b0, 2, 0, 1'b1, "hold_lw2");
        applyStimulus(1'b1, 3'd3, 32'h50, 32'hFFFFFFFF, 32'h0, 1'b1, 1, 0, 1'b1, "hold_err");

        repeat (3) @(negedge clk);
        checkOutput("queue_empty", 32'(expQ.size()), 32'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule
